// File: rtl/cc_base.sv
// rtl/cc_base.sv - rate-1/2 K=7 tail-biting convolutional encoder (171/133), ping-pong block buffers
// Serial bits fill one bank while the other bank is encoded, one coded symbol per cycle.
module cc_base #(
   parameter int BLOCK_BITS = 48
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_in,
   input  logic       cur_in,
   output logic [1:0] z,
   output logic       valid_out
);

   localparam int N  = BLOCK_BITS;
   localparam int IW = $clog2(N);

   typedef enum logic {IDLE, ENCODE} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   bank0_q, bank0_d;
   logic [N-1:0]   bank1_q, bank1_d;
   logic [1:0]     full_q, full_d;
   logic           fill_bank_q, fill_bank_d;
   logic           enc_bank_q, enc_bank_d;
   logic [IW-1:0]  wr_idx_q, wr_idx_d;
   logic [IW-1:0]  step_q, step_d;
   logic [5:0]     sr_q, sr_d;
   logic [1:0]     z_q, z_d;
   logic           valid_q, valid_d;

   logic [N-1:0]   enc_data;
   logic [5:0]     cur_sr;
   logic [IW-1:0]  cur_idx;
   logic           go;
   logic           b;

   always_comb begin
      bank0_d     = bank0_q;
      bank1_d     = bank1_q;
      wr_idx_d    = wr_idx_q;
      fill_bank_d = fill_bank_q;
      full_d      = full_q;
      state_d     = state_q;
      step_d      = step_q;
      sr_d        = sr_q;
      enc_bank_d  = enc_bank_q;
      z_d         = 2'b00;
      valid_d     = 1'b0;
      enc_data    = enc_bank_q ? bank1_q : bank0_q;
      cur_sr      = sr_q;
      cur_idx     = step_q;
      go          = 1'b0;

      if (valid_in) begin
         if (fill_bank_q) bank1_d[wr_idx_q] = cur_in;
         else             bank0_d[wr_idx_q] = cur_in;
         if (wr_idx_q == IW'(N - 1)) begin
            wr_idx_d               = '0;
            full_d[fill_bank_q]    = 1'b1;
            fill_bank_d            = ~fill_bank_q;
         end else begin
            wr_idx_d = wr_idx_q + IW'(1);
         end
      end

      // Step 0 is produced straight from IDLE using the tail-biting preload (last 6 block bits).
      case (state_q)
         IDLE: begin
            if (full_q[enc_bank_q]) begin
               go      = 1'b1;
               cur_idx = '0;
               for (int k = 1; k <= 6; k++) cur_sr[k-1] = enc_data[N-k];
            end
         end
         ENCODE: go = 1'b1;
         default: go = 1'b0;
      endcase

      b = enc_data[cur_idx];

      if (go) begin
         z_d     = {b ^ cur_sr[1] ^ cur_sr[2] ^ cur_sr[4] ^ cur_sr[5],
                    b ^ cur_sr[0] ^ cur_sr[1] ^ cur_sr[2] ^ cur_sr[5]};
         valid_d = 1'b1;
         sr_d    = {cur_sr[4:0], b};
         if (cur_idx == IW'(N - 1)) begin
            state_d            = IDLE;
            step_d             = '0;
            full_d[enc_bank_q] = 1'b0;
            enc_bank_d         = ~enc_bank_q;
         end else begin
            state_d = ENCODE;
            step_d  = cur_idx + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         bank0_q     <= '0;
         bank1_q     <= '0;
         full_q      <= 2'b00;
         fill_bank_q <= 1'b0;
         enc_bank_q  <= 1'b0;
         wr_idx_q    <= '0;
         step_q      <= '0;
         sr_q        <= '0;
         z_q         <= 2'b00;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         bank0_q     <= bank0_d;
         bank1_q     <= bank1_d;
         full_q      <= full_d;
         fill_bank_q <= fill_bank_d;
         enc_bank_q  <= enc_bank_d;
         wr_idx_q    <= wr_idx_d;
         step_q      <= step_d;
         sr_q        <= sr_d;
         z_q         <= z_d;
         valid_q     <= valid_d;
      end
   end

   assign z         = z_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_cc_base.sv
// tb/tb_cc_base.sv - scoreboard bench for cc_base
// Expected symbols carry the cycle they must appear on; a negedge monitor pops and compares.
module tb_cc_base;

   logic       clk;
   logic       reset_n;
   logic       valid_in;
   logic       cur_in;
   logic [1:0] z;
   logic       valid_out;

   int vectors;
   int miscompares;
   int cyc;

   typedef struct {
      int         cyc;
      logic [1:0] z;
   } exp_t;

   exp_t       sb[$];
   logic [1:0] exp_tab[48];

   cc_base #(.BLOCK_BITS(48)) dut (
      .clk       (clk),
      .reset     (reset_n),
      .valid_in  (valid_in),
      .cur_in    (cur_in),
      .z         (z),
      .valid_out (valid_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (valid_out) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_symbol: got z=%b at cyc=%0d, want no valid output", z, cyc);
         end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.z !== z) begin
               miscompares++;
               $display("FAIL symbol: got z=%b cyc=%0d, want z=%b cyc=%0d", z, cyc, e.z, e.cyc);
            end
         end
      end else begin
         vectors++;
         if (z !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_z: got z=%b, want 00 while valid_out=0 (cyc=%0d)", z, cyc);
         end
         if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            miscompares++;
            $display("FAIL missing_symbol: got valid_out=0 at cyc=%0d, want z=%b valid at cyc=%0d", cyc, e.z, e.cyc);
         end
      end
   end

   function automatic logic [1:0] model_sym(input logic [47:0] d, input int k);
      logic [6:0] t;
      for (int j = 0; j <= 6; j++) t[j] = d[(k - j + 48) % 48];
      return {t[0] ^ t[2] ^ t[3] ^ t[5] ^ t[6], t[0] ^ t[1] ^ t[2] ^ t[3] ^ t[6]};
   endfunction

   task automatic fill_model(input logic [47:0] d);
      for (int k = 0; k < 48; k++) exp_tab[k] = model_sym(d, k);
   endtask

   task automatic send_bits(input logic [47:0] d, input int count, input bit gap);
      exp_t e;
      for (int i = 0; i < count; i++) begin
         valid_in = 1'b1;
         cur_in   = d[i];
         @(posedge clk);
         #1;
         if (i == 47) begin
            for (int k = 0; k < 48; k++) begin
               e.cyc = cyc + 1 + k;
               e.z   = exp_tab[k];
               sb.push_back(e);
            end
         end
         valid_in = 1'b0;
         cur_in   = 1'b0;
         if (gap) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d symbols outstanding, want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      sb.delete();
      #1;
      vectors++;
      if (valid_out !== 1'b0 || z !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_%s: got valid_out=%b z=%b, want 0 00", tag, valid_out, z);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   localparam logic [47:0] D1 = 48'hA5C3_1E7F_9B24;
   localparam logic [47:0] D2 = 48'h3D90_C6E1_58AF;
   localparam logic [47:0] D3 = 48'hF00D_4B21_C7E6;

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      valid_in    = 1'b0;
      cur_in      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (valid_out !== 1'b0 || z !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_state: got valid_out=%b z=%b, want 0 00", valid_out, z);
      end
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int k = 0; k < 48; k++) exp_tab[k] = 2'b00;
      send_bits(48'h0, 48, 1'b0);
      wait_drain();

      for (int k = 0; k < 48; k++) exp_tab[k] = 2'b00;
      exp_tab[0] = 2'b11; exp_tab[1] = 2'b01; exp_tab[2] = 2'b11; exp_tab[3] = 2'b11;
      exp_tab[4] = 2'b00; exp_tab[5] = 2'b10; exp_tab[6] = 2'b11;
      send_bits(48'h0000_0000_0001, 48, 1'b0);
      wait_drain();

      for (int k = 0; k < 48; k++) exp_tab[k] = 2'b00;
      exp_tab[0] = 2'b01; exp_tab[1] = 2'b11; exp_tab[2] = 2'b11; exp_tab[3] = 2'b00;
      exp_tab[4] = 2'b10; exp_tab[5] = 2'b11; exp_tab[47] = 2'b11;
      send_bits(48'h8000_0000_0000, 48, 1'b0);
      wait_drain();

      fill_model(D1);
      send_bits(D1, 48, 1'b0);
      fill_model(D2);
      send_bits(D2, 48, 1'b0);
      wait_drain();

      fill_model(D1);
      send_bits(D1, 48, 1'b1);
      wait_drain();

      send_bits(D2, 20, 1'b0);
      do_reset("mid_block");

      fill_model(D3);
      send_bits(D3, 48, 1'b0);
      repeat (11) @(posedge clk);
      #1;
      do_reset("mid_encode");

      fill_model(D1);
      send_bits(D1, 48, 1'b0);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running at %0t, want completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
